// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared types and constants for FFT stage sequencers.
// Holds the stage FSM encoding and the rotator phase width.
package fft_ctrl_pkg;

  localparam int PHI_W    = 6;
  localparam int NMAX_LOG = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/twiddle_phase_gen.sv
// twiddle_phase_gen: maps in-block index to rotator phase.
// First half rotates by j*pi/L, second half passes unrotated.
module twiddle_phase_gen
  import fft_ctrl_pkg::*;
#(
  parameter int STAGE_LOG = 6
) (
  input  logic                 half,
  input  logic [STAGE_LOG-1:0] j,
  output logic [PHI_W-1:0]     phi,
  output logic                 rot_en
);

  // phase word in units of pi/64, scaled from the block index
  always_comb begin
    phi    = '0;
    rot_en = 1'b0;
    if (!half) begin
      rot_en = 1'b1;
      phi    = PHI_W'(j) << (PHI_W - STAGE_LOG);
    end
  end

endmodule

// File: rtl/r2sdf_stage_ctrl.sv
// r2sdf_stage_ctrl: sequencer for one R2SDF FFT stage.
// Sample counter, prime/run FSM and registered stage controls.
module r2sdf_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int STAGE_LOG = 6,
  parameter int N_LOG     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sop,
  output logic             dly_en,
  output logic             bf_mode,
  output logic             rot_en,
  output logic [PHI_W-1:0] phi,
  output logic             out_valid,
  output logic             out_sop,
  output logic             sync_err
);

  localparam logic [N_LOG-1:0] CNT_L =
    N_LOG'(1) << STAGE_LOG;
  localparam logic [STAGE_LOG-1:0] J_LAST = '1;

  state_t               state;
  state_t               state_nx;
  logic [N_LOG-1:0]     cnt;
  logic [N_LOG-1:0]     cnt_nx;
  logic [N_LOG-1:0]     ecnt;
  logic [STAGE_LOG-1:0] j;
  logic                 half;
  logic                 sop_v;
  logic                 take;
  logic                 resync;
  logic [PHI_W-1:0]     phi_nx;
  logic                 rot_nx;
  logic                 ov_nx;
  logic                 os_nx;
  logic                 se_nx;

  assign dly_en = in_valid;
  assign sop_v  = in_valid & in_sop;
  assign ecnt   = sop_v ? '0 : cnt;
  assign half   = ecnt[STAGE_LOG];
  assign j      = ecnt[STAGE_LOG-1:0];
  assign take   = in_valid & ((state != IDLE) | in_sop);
  assign resync = sop_v & (state != IDLE) & (cnt != '0);

  twiddle_phase_gen #(
    .STAGE_LOG(STAGE_LOG)
  ) u_tw (
    .half  (half),
    .j     (j),
    .phi   (phi_nx),
    .rot_en(rot_nx)
  );

  // next state, next count and per-sample output flags
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ov_nx    = 1'b0;
    os_nx    = 1'b0;
    se_nx    = 1'b0;
    if (take) cnt_nx = ecnt + N_LOG'(1);
    unique case (state)
      IDLE: begin
        if (sop_v) state_nx = PRIME;
      end
      PRIME: begin
        if (resync) begin
          se_nx = 1'b1;
        end else if (in_valid && j == J_LAST) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (resync) begin
          se_nx    = 1'b1;
          state_nx = PRIME;
        end else if (in_valid) begin
          ov_nx = 1'b1;
          os_nx = (ecnt == CNT_L);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // stage controls, held across stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_mode   <= 1'b0;
      rot_en    <= 1'b0;
      phi       <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= ov_nx;
      out_sop   <= os_nx;
      sync_err  <= se_nx;
      if (take) begin
        bf_mode <= half;
        rot_en  <= rot_nx;
        phi     <= phi_nx;
      end
    end
  end

endmodule

// File: tb/tb_r2sdf_stage_ctrl.sv
// tb_r2sdf_stage_ctrl: bench for two stage sequencer configs.
// Vector table, directed corner sequences and a random model run.
module tb_r2sdf_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_sop;
  logic       dly_en_a, bf_a, rot_a, ov_a, os_a, se_a;
  logic       dly_en_b, bf_b, rot_b, ov_b, os_b, se_b;
  logic [5:0] phi_a, phi_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  r2sdf_stage_ctrl #(.STAGE_LOG(2), .N_LOG(3)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sop(in_sop),
    .dly_en(dly_en_a), .bf_mode(bf_a), .rot_en(rot_a),
    .phi(phi_a), .out_valid(ov_a), .out_sop(os_a),
    .sync_err(se_a)
  );

  r2sdf_stage_ctrl #(.STAGE_LOG(6), .N_LOG(7)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sop(in_sop),
    .dly_en(dly_en_b), .bf_mode(bf_b), .rot_en(rot_b),
    .phi(phi_b), .out_valid(ov_b), .out_sop(os_b),
    .sync_err(se_b)
  );

  // reference model: frame position plus samples since last (re)sync
  int ml [2] = '{4, 64};
  int mn [2] = '{8, 128};
  bit started [2];
  int pos [2];
  int filled [2];
  bit e_bf [2];
  bit e_rot [2];
  bit e_ov [2];
  bit e_os [2];
  bit e_se [2];
  int e_phi [2];

  typedef struct {
    bit       s;
    bit       ov;
    bit       bf;
    bit [5:0] phi;
    bit       os;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      started[d] = 0; pos[d] = 0; filled[d] = 0;
      e_bf[d] = 0; e_rot[d] = 0; e_phi[d] = 0;
      e_ov[d] = 0; e_os[d] = 0; e_se[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input bit v, input bit s);
    e_ov[d] = 0; e_os[d] = 0; e_se[d] = 0;
    if (v && (started[d] || s)) begin
      if (s) begin
        if (!started[d] || pos[d] != 0) filled[d] = 0;
        if (started[d] && pos[d] != 0) e_se[d] = 1;
        started[d] = 1;
        pos[d] = 0;
      end
      e_ov[d]  = filled[d] >= ml[d];
      e_os[d]  = e_ov[d] && pos[d] == ml[d];
      e_bf[d]  = ((pos[d] / ml[d]) % 2) == 1;
      e_rot[d] = !e_bf[d];
      e_phi[d] = e_bf[d] ? 0 : (pos[d] % ml[d]) * (64 / ml[d]);
      if (filled[d] < ml[d]) filled[d]++;
      pos[d] = (pos[d] + 1) % mn[d];
    end
  endtask

  task automatic cmp_all(input string t);
    chk({t, " a.bf_mode"},   bf_a, e_bf[0]);
    chk({t, " a.rot_en"},    rot_a, e_rot[0]);
    chk({t, " a.phi"},       phi_a, e_phi[0]);
    chk({t, " a.out_valid"}, ov_a, e_ov[0]);
    chk({t, " a.out_sop"},   os_a, e_os[0]);
    chk({t, " a.sync_err"},  se_a, e_se[0]);
    chk({t, " b.bf_mode"},   bf_b, e_bf[1]);
    chk({t, " b.rot_en"},    rot_b, e_rot[1]);
    chk({t, " b.phi"},       phi_b, e_phi[1]);
    chk({t, " b.out_valid"}, ov_b, e_ov[1]);
    chk({t, " b.out_sop"},   os_b, e_os[1]);
    chk({t, " b.sync_err"},  se_b, e_se[1]);
  endtask

  task automatic step(input bit v, input bit s, input string t);
    in_valid = v;
    in_sop   = s;
    #1;
    chk({t, " a.dly_en"}, dly_en_a, v);
    chk({t, " b.dly_en"}, dly_en_b, v);
    @(posedge clk);
    #1;
    model_step(0, v, s);
    model_step(1, v, s);
    cmp_all(t);
  endtask

  task automatic do_reset(input string t);
    in_valid = 0;
    in_sop   = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    cmp_all(t);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    for (int i = 0; i < 16; i++) begin
      tbl[i].s   = (i % 8) == 0;
      tbl[i].ov  = i >= 4;
      tbl[i].bf  = ((i / 4) % 2) == 1;
      tbl[i].phi = tbl[i].bf ? 6'd0 : 6'((i % 4) * 16);
      tbl[i].os  = (i == 4) || (i == 12);
    end

    rst_n = 0; in_valid = 0; in_sop = 0;
    model_reset();
    #1;
    cmp_all("reset");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // scenario 1: table-driven 16-sample stream
    for (int i = 0; i < 16; i++) begin
      step(1'b1, tbl[i].s, "tbl");
      chk($sformatf("tbl%0d ov", i), ov_a, tbl[i].ov);
      chk($sformatf("tbl%0d bf", i), bf_a, tbl[i].bf);
      chk($sformatf("tbl%0d phi", i), phi_a, tbl[i].phi);
      chk($sformatf("tbl%0d os", i), os_a, tbl[i].os);
    end

    // scenario 2: full 64-point span, second frame phase ramp
    do_reset("rst2");
    for (int k = 0; k < 256; k++) begin
      step(1'b1, (k % 128) == 0, "ramp");
      if (k >= 128) begin
        chk("ramp b.phi", phi_b, (k - 128) < 64 ? k - 128 : 0);
        chk("ramp b.rot", rot_b, (k - 128) < 64);
      end
    end

    // scenario 3: same stream as the table with random idle gaps
    do_reset("rst3");
    idx = 0;
    for (int c = 0; c < 300 && idx < 16; c++) begin
      if ($urandom_range(0, 99) < 30) begin
        step(1'b0, 1'($urandom_range(0, 1)), "gap");
        chk("gap ov", ov_a, 0);
      end else begin
        step(1'b1, tbl[idx].s, "gapv");
        chk($sformatf("gap%0d ov", idx), ov_a, tbl[idx].ov);
        chk($sformatf("gap%0d bf", idx), bf_a, tbl[idx].bf);
        chk($sformatf("gap%0d phi", idx), phi_a, tbl[idx].phi);
        chk($sformatf("gap%0d os", idx), os_a, tbl[idx].os);
        idx++;
      end
    end
    chk("gap samples done", idx, 16);

    // scenario 4: stray sop at count 5 in RUN
    do_reset("rst4");
    for (int k = 0; k < 13; k++) step(1'b1, (k % 8) == 0, "pre");
    step(1'b1, 1'b1, "stray");
    chk("stray se", se_a, 1);
    chk("stray ov", ov_a, 0);
    chk("stray phi", phi_a, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, "reprime");
      chk("reprime ov", ov_a, 0);
      chk("reprime se", se_a, 0);
    end
    step(1'b1, 1'b0, "resumed");
    chk("resumed ov", ov_a, 1);
    chk("resumed os", os_a, 1);

    // scenario 5: async reset mid-frame, then non-sop samples
    do_reset("rst5");
    step(1'b1, 1'b1, "mid");
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, "mid");
    do_reset("midrst");
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, "nosop");
      chk("nosop ov", ov_a, 0);
      chk("nosop phi", phi_a, 0);
    end
    step(1'b1, 1'b1, "restart");
    chk("restart rot", rot_a, 1);
    chk("restart ov", ov_a, 0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, "restart");

    // scenario 6: random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      bit v;
      bit s;
      if ($urandom_range(0, 299) == 0) do_reset("rrst");
      v = $urandom_range(0, 99) < 70;
      if (pos[0] == 0) s = $urandom_range(0, 1) == 1;
      else s = $urandom_range(0, 99) < 4;
      step(v, s, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
